// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port register file: sweep state
// encoding, default geometry, and the register-address validity test.
package reg_file_pkg;

  localparam int RF_XLEN  = 64;
  localparam int RF_NREGS = 32;
  localparam int RF_NRD   = 2;
  localparam int RF_NWR   = 2;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  // Register 0 is hard-wired zero and addresses past the array do not exist,
  // so neither may be written nor return stored data.
  function automatic logic rf_addr_ok(input int unsigned addr, input int unsigned nregs);
    return (addr != 0) && (addr < nregs);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero-latency, zero for r0/out-of-range/disabled,
// same-cycle bypass from the highest-index matching write port.
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NWR   = RF_NWR
) (
  input  logic                               en,
  input  logic [$clog2(NREGS)-1:0]           rs,
  input  logic [NREGS-1:0][XLEN-1:0]         regs,
  input  logic [NWR-1:0]                     we,
  input  logic [NWR*$clog2(NREGS)-1:0]       rd,
  input  logic [NWR*XLEN-1:0]                wdata,
  output logic [XLEN-1:0]                    rdata
);

  localparam int AW = $clog2(NREGS);

  always_comb begin
    rdata = '0;
    if (en && rf_addr_ok(32'(rs), NREGS)) begin
      rdata = regs[rs];
      // Ascending scan: a later (higher-index) match overrides earlier ones.
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && (rd[w*AW +: AW] == rs)) begin
          rdata = wdata[w*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with zero-latency bypassed reads and a post-reset
// clear sweep (NREGS-1 cycles); writes are ignored until ready_out is high.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = RF_NRD,
  parameter int NWR   = RF_NWR
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NRD*$clog2(NREGS)-1:0]  rs_in,
  input  logic [NWR*$clog2(NREGS)-1:0]  rd_in,
  input  logic [NWR*XLEN-1:0]           wdata_in,
  input  logic [NWR-1:0]                we_in,
  output logic [NRD*XLEN-1:0]           rdata_out,
  output logic                          ready_out
);

  localparam int AW = $clog2(NREGS);

  rf_state_t                   state, state_nxt;
  logic [AW-1:0]               cnt, cnt_nxt;
  logic [NREGS-1:0][XLEN-1:0]  regs;
  logic                        rd_en;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= RF_CLEAR;
      cnt   <= AW'(1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RF_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == AW'(NREGS - 1)) begin
          state_nxt = RF_READY;
        end
      end
      RF_READY: state_nxt = RF_READY;
      default:  state_nxt = RF_CLEAR;
    endcase
  end

  assign ready_out = (state == RF_READY);
  // Reads stay zero while reset is held, even on the cycle before it takes effect.
  assign rd_en     = ready_out && !rst_in;

  // Data flops carry no reset; the sweep is the only thing that zeroes them.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (state == RF_CLEAR) begin
        regs[cnt] <= '0;
      end else begin
        for (int w = 0; w < NWR; w++) begin
          if (we_in[w] && rf_addr_ok(32'(rd_in[w*AW +: AW]), NREGS)) begin
            regs[rd_in[w*AW +: AW]] <= wdata_in[w*XLEN +: XLEN];
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    rf_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NWR   (NWR)
    ) u_rd (
      .en    (rd_en),
      .rs    (rs_in[p*AW +: AW]),
      .regs  (regs),
      .we    (we_in),
      .rd    (rd_in),
      .wdata (wdata_in),
      .rdata (rdata_out[p*XLEN +: XLEN])
    );
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clk_in and rst_in are the first two ports.
REQ-002 Parameter XLEN, default 64, SHALL set the register data width in bits.
REQ-003 Parameter NREGS, default 32, SHALL set the register count; legal range is 2..64.
REQ-004 Parameter NRD, default 2, SHALL set the number of read ports.
REQ-005 Parameter NWR, default 2, SHALL set the number of write ports.
REQ-006 Local AW = $clog2(NREGS) SHALL set the register-address width.
REQ-007 Port clk_in, input, 1 bit: rising-edge clock.
REQ-008 Port rst_in, input, 1 bit: synchronous reset, active high.
REQ-009 Port rs_in, input, NRD*AW bits: read addresses; port i uses slice [i*AW +: AW].
REQ-010 Port rd_in, input, NWR*AW bits: write addresses, sliced the same way per write port.
REQ-011 Port wdata_in, input, NWR*XLEN bits: write data, one XLEN slice per write port.
REQ-012 Port we_in, input, NWR bits: per-write-port write enable.
REQ-013 Port rdata_out, output, NRD*XLEN bits: read data, one XLEN slice per read port.
REQ-014 Port ready_out, output, 1 bit: the register clear sweep is complete and writes are accepted.

Function
REQ-015 Register 0 SHALL always read as zero, and writes to it SHALL be discarded.
REQ-016 Reads SHALL be combinational: rdata_out reflects the register array in the same cycle with zero latency.
REQ-017 Read bypass: if any write port in the same cycle has we=1, a matching nonzero rd, and ready_out=1, the read SHALL return that port's wdata instead of the stored value.
REQ-018 Bypass priority: when several write ports match a read address, the highest-index port SHALL supply the bypassed data.
REQ-019 Writes SHALL commit on the rising clk_in edge when we=1 and ready_out=1.
REQ-020 Write conflict: when several write ports target the same register in one cycle, the highest-index port SHALL win and the others SHALL be dropped.
REQ-021 Out-of-range addresses (at or above NREGS): reads SHALL return 0 and writes SHALL be dropped.
REQ-022 The state machine SHALL have exactly two states, CLEAR and READY; ready_out = (state == READY).
REQ-023 CLEAR: each clock edge with rst_in=0 SHALL write zero to register[cnt] and then increment cnt.
REQ-024 CLEAR to READY: the edge that clears register NREGS-1 SHALL also move the state to READY.
REQ-025 CLEAR timing: ready_out SHALL rise after exactly NREGS-1 edges with rst_in low (31 edges at default parameters).
REQ-026 In CLEAR, we_in SHALL be ignored, bypass SHALL be disabled, and all rdata_out slices SHALL read 0.
REQ-027 READY SHALL persist until rst_in is asserted; there is no other exit.

Reset
REQ-028 On any edge with rst_in=1, the state SHALL become CLEAR, cnt SHALL become 1, and ready_out SHALL become 0.
REQ-029 Reset asserted mid-sweep SHALL restart the sweep from cnt=1; no partial-sweep state is retained.
REQ-030 Reset SHALL take priority over every write and every sweep step in the same edge.
REQ-031 rdata_out SHALL be all zeros while rst_in=1 and throughout CLEAR.

Structure
REQ-032 Package reg_file_pkg SHALL hold the state enum (RF_CLEAR, RF_READY) and the default XLEN/NREGS/NRD/NWR constants.
REQ-033 Sub-module rf_read_port SHALL implement one read port (zero-forcing, out-of-range check, priority bypass mux); it is instantiated NRD times in a generate loop.
REQ-034 The register array SHALL be a flop array with no reset on the data itself; zeroing is done only by the sweep.

Verification
REQ-035 Sweep: preload registers with 0xFFFF_FFFF_FFFF_FFFF, pulse rst_in for 1 cycle -> ready_out=0 for 31 edges, then 1; all 31 nonzero registers read 0.
REQ-036 Basic write/read: we[0]=1, rd=5, wdata=0x1234 -> same cycle rs[0]=5 returns 0x1234 via bypass; next cycle it returns 0x1234 from storage.
REQ-037 Conflict: port 0 writes 0xAAAA and port 1 writes 0xBBBB, both to register 7 -> register 7 reads 0xBBBB, both bypassed and stored.
REQ-038 Register 0: write 0xDEAD to rd=0 -> rs=0 reads 0 in the same cycle and in later cycles.
REQ-039 Mid-sweep reset: assert rst_in at sweep edge 10 -> ready_out rises exactly 31 edges after rst_in falls; writes issued during CLEAR leave no trace.
REQ-040 Parameter sweep: NREGS=16, NRD=3, NWR=1 -> sweep takes 15 edges; all 3 read ports return correct data on random traffic checked against a reference model.
